ysyx_lsu_mem_resp: RTL
======================

Name: ysyx_lsu_mem_resp

Overview:
- Memory-side responder for the LSU load/store bus: the target end of the araddr/arvalid/rstrb and awaddr/awvalid/wdata/wstrb/wvalid request channels.
- Holds a word-organised SRAM model. Accepts one request at a time, waits a programmable latency, then returns rdata with rvalid, or acknowledges with wready.
- Used as the data-memory model in NPC simulation, and as a bus target behind the LSU in unit benches.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_WORDS, 1024, SRAM depth in DATA_W words (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from acceptance to response (0 treated as 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lsu_araddr  in  ADDR_W  load byte address
lsu_arvalid  in  1  load request
lsu_rstrb  in  8  load byte mask: 8'h1 byte, 8'h3 half, 8'hf word
lsu_rdata  out  DATA_W  load data, right-aligned (addressed byte in [7:0])
lsu_rvalid  out  1  load response strobe, one cycle
lsu_awaddr  in  ADDR_W  store byte address
lsu_awvalid  in  1  store address valid
lsu_wdata  in  DATA_W  store data, right-aligned
lsu_wstrb  in  8  store byte mask, same encoding as rstrb
lsu_wvalid  in  1  store data valid
lsu_wready  out  1  store completion strobe, one cycle
lsu_err  out  1  error flag, valid only with rvalid/wready

Behaviour:
- Reset: async on rst high. State IDLE, counter 0; lsu_rvalid, lsu_wready, lsu_err = 0; lsu_rdata = 0. SRAM contents are not reset.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - A store is accepted when awvalid & wvalid.
  - Otherwise a load is accepted when arvalid.
  - If both are present, the store wins. The load stays pending and is accepted after TURN.
  - On acceptance: latch address, strobe, wdata and op into request registers; load counter with max(LATENCY,1)-1; go to WAIT.
- WAIT: counter decrements each cycle. At 0, perform the SRAM access and go to RESP.
- RESP: lsu_rvalid or lsu_wready is high for exactly this cycle, and lsu_err is driven. Next state TURN.
- TURN: one dead cycle in which all requests are ignored, because the LSU may still hold valid in the cycle after the response. Then IDLE.
- Latency: acceptance at cycle N gives the response at cycle N+1+max(LATENCY,1).
- Word index: (addr-BASE_ADDR)>>2; byte offset off = addr[1:0].
- Out of range: (addr-BASE_ADDR) >= MEM_WORDS*4, or addr < BASE_ADDR. Then err=1, rdata=0, and the store is dropped.
- Misaligned: half with off[0]=1, or word with off!=0. Then err=1 and the access proceeds on the lanes within the word; lanes beyond byte 3 are discarded.
- Load: rdata = word >> (8*off), masked to the rstrb width (0xff, 0xffff, 0xffffffff). The LSU performs sign extension.
- Store: byte-enable = wstrb[3:0] << off, truncated to 4 bits; lane data = wdata << (8*off). Only enabled bytes are written.
- Strobe value other than 1/3/f: no bytes are accessed, err=1, and a response is still returned.
- lsu_rdata holds its last value outside RESP. rvalid and wready are never high together.
- rst asserted mid-transaction: the transaction is abandoned with no response and no SRAM write.

Optional Feature:
- Macro YSYX_LSU_RESP_RAND_LAT_EN.
- Defined: the counter load value comes from a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset). Latency = (lfsr[2:0])+1, range 1..8. The LFSR advances once per accepted request.
- Undefined: fixed LATENCY and no LFSR logic.

Decomposition:
- Shared package/macro header: state encoding constants, strobe encodings (BYTE=8'h1, HALF=8'h3, WORD=8'hf), BASE_ADDR default.
- One natural sub-module, ysyx_lsu_mem_lane, which is combinational: off + strobe + wdata → byte-enable, shifted write data, aligned/masked read data, misalign/bad-strobe flag.
- The FSM, counter, LFSR and SRAM array stay in the top module.

Test Plan:
- Store word: awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=f, LATENCY=2 → wready at acceptance+3, err=0. Then load word at 0x8000_0010 → rdata=0xDEADBEEF.
- Byte lanes: store byte 0x5A at 0x8000_0013, then load word at 0x8000_0010 → 0x5AADBEEF. Load byte (rstrb=1) at 0x8000_0013 → rdata=0x0000005A.
- Half load at 0x8000_0012 → 0x00005AAD. Half load at 0x8000_0011 → err=1, response still returned.
- Simultaneous arvalid+awvalid+wvalid in IDLE → store acknowledged first. Load rvalid follows after TURN with the post-store data. No cycle has rvalid&wready.
- Out of range: load at 0x7FFF_FFFC → rvalid with rdata=0, err=1. Store at BASE+MEM_WORDS*4 → wready with err=1; memory unchanged.
- Held request: keep arvalid high continuously → back-to-back responses spaced LATENCY+3 cycles. Assert rst in WAIT → no rvalid; outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_lsu_mem_resp_pkg.sv
// Shared definitions for the LSU memory responder: FSM state encoding,
// access-strobe encodings, default base address and the latency LFSR step.
package ysyx_lsu_mem_resp_pkg;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    // Access size strobes carried on rstrb/wstrb
    localparam logic [7:0] STRB_BYTE = 8'h01;
    localparam logic [7:0] STRB_HALF = 8'h03;
    localparam logic [7:0] STRB_WORD = 8'h0f;

    // Byte address of SRAM word 0 in the NPC memory map
    localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;

    // Galois LFSR, taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ysyx_lsu_mem_lane.sv
// Byte-lane steering for one 32-bit SRAM word: turns byte offset + size
// strobe into write byte-enables, shifted write data, right-aligned masked
// read data and an error flag (misaligned access or unknown strobe).
module ysyx_lsu_mem_lane
    import ysyx_lsu_mem_resp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        off_i,
    input  logic [7:0]        strb_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rword_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wlane_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    logic [DATA_W-1:0] mask;
    logic              bad_strb;
    logic              misalign;
    logic [4:0]        shamt;

    // Decode the size strobe, then steer lanes by the byte offset; lanes
    // pushed past byte 3 simply fall off the top of the word.
    always_comb begin
        mask     = '0;
        bad_strb = 1'b0;
        misalign = 1'b0;
        shamt    = {off_i, 3'b000};
        case (strb_i)
            STRB_BYTE: mask = DATA_W'(32'h0000_00ff);
            STRB_HALF: begin
                mask     = DATA_W'(32'h0000_ffff);
                misalign = off_i[0];
            end
            STRB_WORD: begin
                mask     = '1;
                misalign = |off_i;
            end
            default:   bad_strb = 1'b1;
        endcase
        be_o    = bad_strb ? 4'b0000 : (strb_i[3:0] << off_i);
        wlane_o = wdata_i << shamt;
        rdata_o = (rword_i >> shamt) & mask;
        err_o   = bad_strb | misalign;
    end

endmodule

// File: rtl/ysyx_lsu_mem_resp.sv
// Memory-side responder for the LSU load/store bus. Accepts one request at a
// time (store wins over load), waits a programmable latency, accesses a
// word-organised SRAM model and returns a one-cycle rvalid/wready, followed
// by one dead turnaround cycle.
// Build option: define YSYX_LSU_RESP_RAND_LAT_EN to draw each request's
// latency (1..8) from a 16-bit LFSR instead of the fixed LATENCY.
module ysyx_lsu_mem_resp
    import ysyx_lsu_mem_resp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic              lsu_err
);

    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int IDX_W   = $clog2(MEM_WORDS);
    // At least 3 bits so the random-latency load value (0..7) always fits
    localparam int CNT_W   = (LAT_EFF > 8) ? $clog2(LAT_EFF) : 3;

    // Control state
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              wready_q, wready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Latched request
    logic              req_store_q, req_store_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [7:0]        req_strb_q, req_strb_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    logic              st_req, ld_req, accept, done;
    logic [CNT_W-1:0]  cnt_load;

    // SRAM model (contents deliberately not reset)
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // Address decode relative to BASE_ADDR
    logic [ADDR_W-1:0] rel;
    logic              oor;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic [DATA_W-1:0] rword;

    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;
    logic              lane_err;

    // Upper-bit test equals rel >= MEM_WORDS*4 since MEM_WORDS is a power of
    // two; addresses below the base wrap and are caught by the compare.
    assign rel   = req_addr_q - BASE_ADDR;
    assign oor   = (req_addr_q < BASE_ADDR) | (|rel[ADDR_W-1:IDX_W+2]);
    assign idx   = rel[IDX_W+1:2];
    assign off   = rel[1:0];
    assign rword = mem_q[idx];

    assign st_req = lsu_awvalid & lsu_wvalid;
    assign ld_req = lsu_arvalid;
    assign done   = (state_q == ST_WAIT) && (cnt_q == '0);

    ysyx_lsu_mem_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .off_i   (off),
        .strb_i  (req_strb_q),
        .wdata_i (req_wdata_q),
        .rword_i (rword),
        .be_o    (lane_be),
        .wlane_o (lane_wdata),
        .rdata_o (lane_rdata),
        .err_o   (lane_err)
    );

`ifdef YSYX_LSU_RESP_RAND_LAT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Step the LFSR once per accepted request
    always_comb begin
        lfsr_d = accept ? lfsr_next(lfsr_q) : lfsr_q;
    end

    // LFSR register, reseeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign cnt_load = CNT_W'(lfsr_q[2:0]);
`else
    assign cnt_load = CNT_W'(LAT_EFF - 1);
`endif

    // Next-state logic: accept, count down, respond, turn around
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rvalid_d    = 1'b0;
        wready_d    = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        accept      = 1'b0;
        req_store_d = req_store_q;
        req_addr_d  = req_addr_q;
        req_strb_d  = req_strb_q;
        req_wdata_d = req_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (st_req || ld_req) begin
                    accept      = 1'b1;
                    req_store_d = st_req;
                    req_addr_d  = st_req ? lsu_awaddr : lsu_araddr;
                    req_strb_d  = st_req ? lsu_wstrb  : lsu_rstrb;
                    req_wdata_d = lsu_wdata;
                    cnt_d       = cnt_load;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    err_d   = oor | lane_err;
                    if (req_store_q) begin
                        wready_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = oor ? '0 : lane_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_TURN;
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers, cleared by async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            wready_q <= wready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Request registers only matter outside IDLE, so they carry no reset
    always_ff @(posedge clk) begin
        req_store_q <= req_store_d;
        req_addr_q  <= req_addr_d;
        req_strb_q  <= req_strb_d;
        req_wdata_q <= req_wdata_d;
    end

    // SRAM byte-lane write at the end of WAIT; out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (done && req_store_q && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    assign lsu_rdata  = rdata_q;
    assign lsu_rvalid = rvalid_q;
    assign lsu_wready = wready_q;
    assign lsu_err    = err_q;

endmodule
